// File: rtl/capture_pkg.sv
// Shared types and sizing for the dual-bank sample capture controller.
package capture_pkg;
    localparam int BUF_DEPTH = 1024;
    localparam int ADDR_W    = 10;
    localparam int OVR_W     = 8;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_PRE       = 3'd1,
        S_WAIT_TRIG = 3'd2,
        S_POST      = 3'd3,
        S_SWAP      = 3'd4
    } state_t;
endpackage

// File: rtl/edge_detect.sv
// Registered edge detector: one-clk rise/fall pulses on a synchronised input.
module edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise,
    output logic fall
);
    logic prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) prev <= 1'b0;
        else     prev <= din;
    end

    assign rise = din & ~prev;
    assign fall = ~din & prev;
endmodule

// File: rtl/capture_ctrl.sv
// Pre/post-trigger capture into a ping-pong sample buffer with host-lock aware bank swap.
module capture_ctrl
    import capture_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              adc_tick,
    input  logic              sig_in,
    input  logic              stable,
    input  logic              arm,
    input  logic              abort,
    input  logic              auto_mode,
    input  logic              trig_fall,
    input  logic [ADDR_W-1:0] pre_trig,
    input  logic              host_lock,
    output logic              buf_we,
    output logic [ADDR_W-1:0] buf_waddr,
    output logic              wr_bank,
    output logic              swap,
    output logic              frame_ready,
    output logic [ADDR_W-1:0] start_addr,
    output logic [OVR_W-1:0]  overrun,
    output logic [2:0]        state
);
    state_t cur, nxt;

    logic [ADDR_W-1:0] ptr, pre_lat, pre_cnt, trig_addr;
    logic [ADDR_W:0]   post_cnt, post_tgt;
    logic              host_lock_d;
    logic              rise, fall, trig;
    logic              wr_req, do_swap, arm_ok, pre_inc, trig_hit, ovr_inc;

    edge_detect u_edge (
        .clk  (clk),
        .rst  (rst),
        .din  (sig_in),
        .rise (rise),
        .fall (fall)
    );

    assign trig     = stable & (trig_fall ? fall : rise);
    // Post-trigger length makes pre + post exactly one full bank.
    assign post_tgt = (ADDR_W+1)'(BUF_DEPTH) - {1'b0, pre_lat};
    assign state    = cur;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cur <= S_IDLE;
        else     cur <= nxt;
    end

    always_comb begin
        nxt      = cur;
        wr_req   = 1'b0;
        do_swap  = 1'b0;
        arm_ok   = 1'b0;
        pre_inc  = 1'b0;
        trig_hit = 1'b0;
        ovr_inc  = 1'b0;
        if (cur != S_IDLE && abort) begin
            nxt = S_IDLE;
        end else begin
            case (cur)
                S_IDLE: begin
                    if (arm && !abort) begin
                        arm_ok = 1'b1;
                        nxt    = S_PRE;
                    end
                end
                S_PRE: begin
                    wr_req  = adc_tick;
                    pre_inc = adc_tick;
                    if (pre_cnt == pre_lat) nxt = S_WAIT_TRIG;
                end
                S_WAIT_TRIG: begin
                    wr_req = adc_tick;
                    if (trig) begin
                        trig_hit = 1'b1;
                        nxt      = S_POST;
                    end
                end
                S_POST: begin
                    // Stop writing at the frame boundary so the oldest pre sample survives.
                    wr_req = adc_tick && (post_cnt < post_tgt);
                    if (post_cnt == post_tgt) nxt = S_SWAP;
                end
                S_SWAP: begin
                    if (!host_lock) begin
                        do_swap = 1'b1;
                        nxt     = auto_mode ? S_PRE : S_IDLE;
                    end else begin
                        ovr_inc = adc_tick;
                    end
                end
                default: nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_we      <= 1'b0;
            buf_waddr   <= '0;
            wr_bank     <= 1'b0;
            swap        <= 1'b0;
            frame_ready <= 1'b0;
            start_addr  <= '0;
            overrun     <= '0;
            ptr         <= '0;
            pre_lat     <= '0;
            pre_cnt     <= '0;
            trig_addr   <= '0;
            post_cnt    <= '0;
            host_lock_d <= 1'b0;
        end else begin
            buf_we      <= wr_req;
            swap        <= do_swap;
            host_lock_d <= host_lock;

            if (wr_req) begin
                buf_waddr <= ptr;
                ptr       <= ptr + 1'b1;
            end
            if (pre_inc) pre_cnt <= pre_cnt + 1'b1;
            if (cur == S_POST && wr_req) post_cnt <= post_cnt + 1'b1;

            if (arm_ok) begin
                pre_lat <= pre_trig;
                pre_cnt <= '0;
                ptr     <= '0;
                overrun <= '0;
            end

            // A tick coinciding with the trigger is the trigger sample itself.
            if (trig_hit) begin
                trig_addr <= ptr;
                post_cnt  <= {{ADDR_W{1'b0}}, adc_tick};
            end

            if (ovr_inc && overrun != {OVR_W{1'b1}}) overrun <= overrun + 1'b1;

            if (do_swap) begin
                wr_bank     <= ~wr_bank;
                frame_ready <= 1'b1;
                start_addr  <= trig_addr - pre_lat;
                if (auto_mode) begin
                    ptr     <= '0;
                    pre_cnt <= '0;
                end
            end else if (host_lock && !host_lock_d) begin
                frame_ready <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_capture_ctrl.sv
// Directed bench for capture_ctrl: hand-computed frame addresses, counts and flags.
module tb_capture_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       adc_tick = 1'b0, sig_in = 1'b0, stable = 1'b1, arm = 1'b0, abort = 1'b0;
    logic       auto_mode = 1'b0, trig_fall = 1'b0, host_lock = 1'b0;
    logic [9:0] pre_trig = '0;
    logic       buf_we, wr_bank, swap, frame_ready;
    logic [9:0] buf_waddr, start_addr;
    logic [7:0] overrun;
    logic [2:0] state;

    int n_chk = 0, n_err = 0;
    int wr_cnt = 0, swap_cnt = 0, gap_cnt = 0;
    logic [9:0] first_addr = '0, prev_addr = '0, exp_next;
    bit have_prev = 0, wrap_seen = 0;

    capture_ctrl dut (
        .clk(clk), .rst(rst), .adc_tick(adc_tick), .sig_in(sig_in), .stable(stable),
        .arm(arm), .abort(abort), .auto_mode(auto_mode), .trig_fall(trig_fall),
        .pre_trig(pre_trig), .host_lock(host_lock), .buf_we(buf_we), .buf_waddr(buf_waddr),
        .wr_bank(wr_bank), .swap(swap), .frame_ready(frame_ready), .start_addr(start_addr),
        .overrun(overrun), .state(state)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (swap) swap_cnt++;
        if (buf_we) begin
            exp_next = prev_addr + 10'd1;
            if (wr_cnt == 0) first_addr = buf_waddr;
            if (have_prev && buf_waddr != exp_next) gap_cnt++;
            if (have_prev && prev_addr == 10'd1023 && buf_waddr == 10'd0) wrap_seen = 1;
            prev_addr = buf_waddr;
            have_prev = 1;
            wr_cnt++;
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            adc_tick = 1'b1; cyc();
            adc_tick = 1'b0; cyc();
        end
    endtask

    task automatic clr_mon();
        wr_cnt = 0; swap_cnt = 0; gap_cnt = 0; have_prev = 0; wrap_seen = 0;
    endtask

    task automatic do_arm(input int pre);
        pre_trig = 10'(pre);
        arm = 1'b1; cyc(); arm = 1'b0;
    endtask

    task automatic trig_edge();
        sig_in = 1'b1; cyc(); sig_in = 1'b0;
    endtask

    initial begin
        cyc(); cyc();
        chk("rst_state", state, 0);
        chk("rst_buf_we", buf_we, 0);
        chk("rst_waddr", buf_waddr, 0);
        chk("rst_wr_bank", wr_bank, 0);
        chk("rst_swap", swap, 0);
        chk("rst_frame_ready", frame_ready, 0);
        chk("rst_start_addr", start_addr, 0);
        chk("rst_overrun", overrun, 0);
        rst = 1'b0; cyc();

        // pre=100, trigger after 300 ticks at address 300
        clr_mon();
        do_arm(100);
        chk("t1_pre_state", state, 1);
        tick_n(300);
        chk("t1_wait_state", state, 2);
        trig_edge();
        chk("t1_post_state", state, 3);
        tick_n(923);
        chk("t1_still_post", state, 3);
        tick_n(1);
        chk("t1_swap_state", state, 4);
        chk("t1_no_swap_yet", swap_cnt, 0);
        cyc();
        chk("t1_swap", swap, 1);
        chk("t1_wr_bank", wr_bank, 1);
        chk("t1_frame_ready", frame_ready, 1);
        chk("t1_start_addr", start_addr, 200);
        chk("t1_idle", state, 0);
        chk("t1_writes", wr_cnt, 1224);
        cyc();
        chk("t1_swap_pulse", swap, 0);
        chk("t1_swap_cnt", swap_cnt, 1);

        // pre=0, trigger coincident with the first tick
        do_arm(0);
        cyc();
        chk("t2_wait_state", state, 2);
        clr_mon();
        sig_in = 1'b1; adc_tick = 1'b1; cyc();
        adc_tick = 1'b0; sig_in = 1'b0;
        chk("t2_first_we", buf_we, 1);
        chk("t2_first_waddr", buf_waddr, 0);
        cyc();
        tick_n(1023);
        cyc();
        chk("t2_swap", swap, 1);
        chk("t2_start_addr", start_addr, 0);
        chk("t2_wr_bank", wr_bank, 0);
        chk("t2_writes", wr_cnt, 1024);
        chk("t2_first_addr", first_addr, 0);

        // host_lock held through SWAP
        host_lock = 1'b1; cyc();
        chk("t3_fr_clear", frame_ready, 0);
        do_arm(0);
        cyc();
        sig_in = 1'b1; adc_tick = 1'b1; cyc();
        adc_tick = 1'b0; sig_in = 1'b0; cyc();
        tick_n(1023);
        chk("t3_swap_state", state, 4);
        clr_mon();
        tick_n(300);
        chk("t3_no_we", wr_cnt, 0);
        chk("t3_overrun", overrun, 255);
        chk("t3_held", state, 4);
        chk("t3_no_swap", swap_cnt, 0);
        host_lock = 1'b0; cyc();
        chk("t3_swap", swap, 1);
        chk("t3_frame_ready", frame_ready, 1);
        chk("t3_wr_bank", wr_bank, 1);

        // auto re-arm, two frames, pointer wraps inside the first
        rst = 1'b1; cyc(); rst = 1'b0;
        auto_mode = 1'b1;
        do_arm(100);
        chk("t4_overrun_clr", overrun, 0);
        clr_mon();
        tick_n(1100);
        trig_edge();
        tick_n(924);
        cyc();
        chk("t4_swap1", swap, 1);
        chk("t4_wr_bank1", wr_bank, 1);
        chk("t4_start1", start_addr, 1000);
        chk("t4_gaps", gap_cnt, 0);
        chk("t4_wrap", wrap_seen, 1);
        chk("t4_writes1", wr_cnt, 2024);
        chk("t4_rearm", state, 1);
        auto_mode = 1'b0;
        tick_n(150);
        trig_edge();
        tick_n(924);
        cyc();
        chk("t4_swap2", swap, 1);
        chk("t4_wr_bank2", wr_bank, 0);
        chk("t4_start2", start_addr, 50);
        chk("t4_idle", state, 0);
        cyc();
        chk("t4_swap_cnt", swap_cnt, 2);

        // abort during POST; arm outside IDLE ignored
        do_arm(10);
        tick_n(20);
        arm = 1'b1; cyc(); arm = 1'b0;
        chk("t5_arm_ignored", state, 2);
        trig_edge();
        tick_n(50);
        chk("t5_post", state, 3);
        clr_mon();
        abort = 1'b1; adc_tick = 1'b1; sig_in = 1'b1; cyc();
        abort = 1'b0; adc_tick = 1'b0; sig_in = 1'b0;
        chk("t5_idle", state, 0);
        tick_n(5);
        chk("t5_no_writes", wr_cnt, 0);
        chk("t5_no_swap", swap_cnt, 0);
        chk("t5_frame_ready", frame_ready, 1);
        chk("t5_wr_bank", wr_bank, 0);
        chk("t5_start_addr", start_addr, 50);

        // reset mid-POST, then a clean capture
        do_arm(10);
        tick_n(20);
        trig_edge();
        tick_n(30);
        adc_tick = 1'b1; cyc(); adc_tick = 1'b0;
        rst = 1'b1; #1;
        chk("t6_state", state, 0);
        chk("t6_buf_we", buf_we, 0);
        chk("t6_waddr", buf_waddr, 0);
        chk("t6_frame_ready", frame_ready, 0);
        chk("t6_start_addr", start_addr, 0);
        chk("t6_swap", swap, 0);
        chk("t6_overrun", overrun, 0);
        cyc(); rst = 1'b0;
        clr_mon();
        tick_n(3);
        trig_edge();
        tick_n(3);
        chk("t6_needs_arm", state, 0);
        chk("t6_no_writes", wr_cnt, 0);
        do_arm(4);
        tick_n(10);
        trig_edge();
        tick_n(1020);
        cyc();
        chk("t6_swap", swap, 1);
        chk("t6_start", start_addr, 6);
        chk("t6_wr_bank", wr_bank, 1);
        chk("t6_writes", wr_cnt, 1030);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/capture_ctrl.md
CAPTURE_CTRL -- requirements
Module: capture_ctrl

Interface
REQ-001 SHALL have a single clock `clk`; reset `rst` SHALL be asynchronous and active-high.
REQ-002 SHALL expose these ports, one per line as name, direction, width, meaning:
- clk  in  1  system clock.
- rst  in  1  async active-high reset.
- adc_tick  in  1  one-clk strobe per ADC sample, already synchronised to clk.
- sig_in  in  1  synchronised comparator square wave.
- stable  in  1  analog front end settled; qualifies triggers.
- arm  in  1  one-clk pulse that starts a capture.
- abort  in  1  one-clk pulse that cancels a capture.
- auto_mode  in  1  re-arm automatically after a swap.
- trig_fall  in  1  0 = rising-edge trigger, 1 = falling-edge trigger.
- pre_trig  in  10  pre-trigger sample count, latched on arm.
- host_lock  in  1  host is reading the read bank (status register bit).
- buf_we  out  1  buffer write enable.
- buf_waddr  out  10  write address within the write bank.
- wr_bank  out  1  bank being written; the read bank is ~wr_bank.
- swap  out  1  one-clk pulse on bank exchange.
- frame_ready  out  1  read bank holds a complete frame.
- start_addr  out  10  address of the oldest sample in the read bank.
- overrun  out  8  saturating count of samples dropped while waiting to swap.
- state  out  3  current FSM state.

Function
REQ-003 SHALL implement states IDLE, PRE, WAIT_TRIG, POST and SWAP.
REQ-004 IDLE: on arm, SHALL latch pre_trig, clear pre_cnt and go to PRE; arm outside IDLE SHALL be ignored.
REQ-005 PRE, WAIT_TRIG and POST: each adc_tick SHALL give buf_we=1 one cycle later, with buf_waddr=ptr; ptr SHALL then increment mod 1024 (1023->0).
REQ-006 PRE: each tick SHALL increment pre_cnt; when pre_cnt==pre_trig, SHALL go to WAIT_TRIG; pre_trig=0 SHALL reach WAIT_TRIG on the next clk.
REQ-007 A trigger SHALL be the selected edge of sig_in (registered edge detect) with stable=1; triggers outside WAIT_TRIG SHALL be ignored.
REQ-008 WAIT_TRIG: writes SHALL continue circularly; on trigger, SHALL latch trig_addr=ptr, set post_cnt=0 and go to POST.
REQ-009 Trigger and adc_tick in the same cycle: that sample SHALL be the trigger sample at trig_addr and SHALL count as post_cnt=1.
REQ-010 POST: SHALL go to SWAP once post_cnt reaches 1024-pre_trig_latched, so each frame is exactly 1024 samples.
REQ-011 SWAP with host_lock=0: SHALL toggle wr_bank, pulse swap for one clk, set frame_ready=1 and set start_addr=(trig_addr-pre_trig_latched) mod 1024.
REQ-012 After a swap, SHALL go to PRE (with ptr=0 and pre_cnt=0) if auto_mode=1, otherwise to IDLE.
REQ-013 SWAP with host_lock=1: SHALL hold the swap; each adc_tick SHALL raise no buf_we and SHALL increment overrun, saturating at 255.
REQ-014 frame_ready SHALL clear on the clk after a host_lock rising edge; a swap in the same cycle SHALL take priority and leave frame_ready=1.
REQ-015 abort in any non-IDLE state SHALL go to IDLE on the next clk with no swap, leaving wr_bank, start_addr and frame_ready unchanged; abort SHALL override arm and trigger.
REQ-016 overrun SHALL clear only on reset or arm.

Reset
REQ-017 Reset SHALL force state=IDLE and buf_we=0, buf_waddr=0, wr_bank=0, swap=0, frame_ready=0, start_addr=0, overrun=0, and clear all internal counters.
REQ-018 On reset mid-capture, SHALL discard the in-progress frame and require a new arm after release.

Structure
REQ-019 Package capture_pkg SHALL hold the state enum, BUF_DEPTH=1024, ADDR_W=10 and OVR_W=8.
REQ-020 Edge detection SHALL be the sub-module edge_detect (rise/fall pulse outputs).

Verification
REQ-021 pre_trig=100, arm, rising trigger after 300 ticks, host_lock=0 -> swap after 924 post ticks, wr_bank=1, start_addr=(trig_addr-100) mod 1024.
REQ-022 pre_trig=0 with trigger and adc_tick in the same cycle -> 1024 writes total, start_addr=trig_addr, first buf_waddr=trig_addr.
REQ-023 host_lock=1 throughout SWAP for 300 ticks -> no buf_we, overrun=255, swap is issued on the first clk after host_lock falls.
REQ-024 auto_mode=1, two triggers -> two swap pulses, wr_bank returns to 0, ptr wraps past 1023 without a gap.
REQ-025 abort during POST -> IDLE next clk, no swap, frame_ready unchanged.
REQ-026 rst asserted mid-POST -> all outputs at reset values immediately; a later arm starts a clean capture.
